// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers and counter mode constants
package gray_pkg;

  localparam bit MODE_WRAP = 1'b1;
  localparam bit MODE_SAT  = 1'b0;

  // Largest code of an n-bit Gray sequence: 1 followed by n-1 zeros.
  function automatic logic [31:0] gray_max(input int n);
    return 32'h1 << (n - 1);
  endfunction

  // Callers zero-extend narrower codes; the zero upper bits leave the low bits exact.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_next_step.sv
// rtl/gray_next_step.sv - combinational single-step Gray successor/predecessor
module gray_next_step
  import gray_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] g,
  input  logic         p,
  input  logic         up_dn,
  output logic [N-1:0] g_next,
  output logic         at_bound
);

  localparam logic [N-1:0] MAX_G = N'(gray_max(N));
  localparam logic [N-1:0] ONE_G = N'(1);

  logic [N-1:0] left_mask;

  // Descending scan, so the lowest set bit below the MSB is the one that sticks.
  always_comb begin
    left_mask = '0;
    for (int i = N - 2; i >= 0; i--) begin
      if (g[i]) left_mask = ONE_G << (i + 1);
    end
  end

  always_comb begin
    g_next   = g;
    at_bound = 1'b0;
    if (up_dn) begin
      if (!p) begin
        g_next = g ^ ONE_G;
      end else if (g == MAX_G) begin
        at_bound = 1'b1;
        g_next   = '0;
      end else begin
        g_next = g ^ left_mask;
      end
    end else begin
      if (p) begin
        g_next = g ^ ONE_G;
      end else if (g == '0) begin
        at_bound = 1'b1;
        g_next   = MAX_G;
      end else begin
        g_next = g ^ left_mask;
      end
    end
  end

endmodule

// File: rtl/gray_updown_counter.sv
// rtl/gray_updown_counter.sv - up/down Gray counter with load, wrap/saturate, tc and wrap pulse
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int N    = 4,
  parameter bit WRAP = MODE_WRAP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] gray_out,
  output logic [N-1:0] bin_out,
  output logic         tc,
  output logic         wrap
);

  localparam logic [N-1:0] MAX_G = N'(gray_max(N));

  logic [N-1:0] g_q, g_d;
  logic         p_q, p_d;
  logic         wrap_q, wrap_d;
  logic [N-1:0] g_next;
  logic         at_bound;

  gray_next_step #(.N(N)) u_step (
    .g        (g_q),
    .p        (p_q),
    .up_dn    (up_dn),
    .g_next   (g_next),
    .at_bound (at_bound)
  );

  // Parity flips on every real step; a saturated boundary step is a hold.
  always_comb begin
    g_d    = g_q;
    p_d    = p_q;
    wrap_d = 1'b0;
    if (load) begin
      g_d = load_val;
      p_d = ^load_val;
    end else if (enable) begin
      if (!at_bound) begin
        g_d = g_next;
        p_d = ~p_q;
      end else if (WRAP == MODE_WRAP) begin
        g_d    = g_next;
        p_d    = ~p_q;
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_q    <= '0;
      p_q    <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      g_q    <= g_d;
      p_q    <= p_d;
      wrap_q <= wrap_d;
    end
  end

  assign gray_out = g_q;
  assign bin_out  = N'(gray2bin(32'(g_q)));
  assign tc       = up_dn ? (g_q == MAX_G) : (g_q == '0);
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb/tb_gray_updown_counter.sv - directed and scoreboard bench for gray_updown_counter
module tb_gray_updown_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_en = 0, a_ud = 1, a_ld = 0;
  logic [3:0] a_lv = '0, a_g, a_b;
  logic       a_tc, a_wr;

  logic       s_en = 0, s_ud = 1, s_ld = 0;
  logic [3:0] s_lv = '0, s_g, s_b;
  logic       s_tc, s_wr;

  logic       r_en = 0, r_ud = 1, r_ld = 0;
  logic [7:0] r_lv = '0, r_g, r_b;
  logic       r_tc, r_wr;

  gray_updown_counter #(.N(4), .WRAP(1'b1)) dut_a (
    .clk(clk), .reset(rst), .enable(a_en), .up_dn(a_ud), .load(a_ld), .load_val(a_lv),
    .gray_out(a_g), .bin_out(a_b), .tc(a_tc), .wrap(a_wr));

  gray_updown_counter #(.N(4), .WRAP(1'b0)) dut_s (
    .clk(clk), .reset(rst), .enable(s_en), .up_dn(s_ud), .load(s_ld), .load_val(s_lv),
    .gray_out(s_g), .bin_out(s_b), .tc(s_tc), .wrap(s_wr));

  gray_updown_counter #(.N(8), .WRAP(1'b1)) dut_r (
    .clk(clk), .reset(rst), .enable(r_en), .up_dn(r_ud), .load(r_ld), .load_val(r_lv),
    .gray_out(r_g), .bin_out(r_b), .tc(r_tc), .wrap(r_wr));

  typedef struct {
    logic       en;
    logic       ud;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] exp_g;
    logic [3:0] exp_b;
    logic       exp_tc;
    logic       exp_wr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] g2b8(input logic [7:0] g);
    logic [7:0] b;
    b = g ^ (g >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    return b;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t       tab[$];
  logic [3:0] gseq [17];
  logic [3:0] prev;
  logic [7:0] ref_b;
  logic       ref_w;
  vec_t       v;

  initial begin
    gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
             4'b0000};
    for (int i = 0; i < 16; i++) begin
      v = '{1'b1, 1'b1, 1'b0, 4'h0, gseq[i+1], 4'((i + 1) % 16),
            (gseq[i+1] == 4'b1000), (i == 15)};
      tab.push_back(v);
    end
    tab.push_back('{1'b1, 1'b1, 1'b1, 4'b1010, 4'b1010, 4'b1100, 1'b0, 1'b0});
    tab.push_back('{1'b1, 1'b1, 1'b0, 4'b0000, 4'b1011, 4'b1101, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++)
      tab.push_back('{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1011, 4'b1101, 1'b0, 1'b0});

    do_reset();
    chk("reset_gray", a_g, 4'b0000);
    chk("reset_bin", a_b, 4'b0000);
    chk("reset_wrap", a_wr, 1'b0);
    chk("reset_tc_up", a_tc, 1'b0);

    // Full up count, then load priority and hold.
    foreach (tab[k]) begin
      prev = a_g;
      a_en = tab[k].en; a_ud = tab[k].ud; a_ld = tab[k].ld; a_lv = tab[k].lv;
      tick();
      chk($sformatf("vec%0d_gray", k), a_g, tab[k].exp_g);
      chk($sformatf("vec%0d_bin", k), a_b, tab[k].exp_b);
      chk($sformatf("vec%0d_tc", k), a_tc, tab[k].exp_tc);
      chk($sformatf("vec%0d_wrap", k), a_wr, tab[k].exp_wr);
      if (k < 16) chk($sformatf("vec%0d_onebit", k), $countones(prev ^ a_g), 1);
    end
    a_en = 0; a_ld = 0;

    // Down from zero wraps to max.
    do_reset();
    a_ud = 0;
    #1;
    chk("down_tc_at_zero", a_tc, 1'b1);
    a_en = 1;
    tick();
    chk("down_wrap_gray", a_g, 4'b1000);
    chk("down_wrap_pulse", a_wr, 1'b1);
    chk("down_wrap_bin", a_b, 4'd15);
    tick();
    chk("down_step2_gray", a_g, 4'b1001);
    chk("down_step2_wrap", a_wr, 1'b0);
    chk("down_step2_bin", a_b, 4'd14);
    a_en = 0;

    // Saturating instance.
    s_ud = 1; s_en = 1;
    for (int i = 0; i < 15; i++) tick();
    chk("sat_top_gray", s_g, 4'b1000);
    chk("sat_top_tc", s_tc, 1'b1);
    chk("sat_top_wrap", s_wr, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat_hold%0d_gray", i), s_g, 4'b1000);
      chk($sformatf("sat_hold%0d_wrap", i), s_wr, 1'b0);
    end
    s_ud = 0;
    tick();
    chk("sat_down_gray", s_g, 4'b1001);
    s_en = 0;

    // Async reset between edges.
    do_reset();
    a_ud = 1; a_en = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_areset_gray", a_g, 4'b0110);
    a_en = 0;
    #3 rst = 1'b1;
    #1;
    chk("areset_gray", a_g, 4'b0000);
    chk("areset_wrap", a_wr, 1'b0);
    chk("areset_bin", a_b, 4'b0000);
    #1 rst = 1'b0;
    a_en = 1;
    tick();
    chk("post_areset_gray", a_g, 4'b0001);
    a_en = 0;

    // Random scoreboard on the 8-bit wrapping instance.
    do_reset();
    ref_b = 8'd0;
    for (int c = 0; c < 5000; c++) begin
      r_en = ($urandom_range(0, 3) != 0);
      r_ud = 1'($urandom_range(0, 1));
      r_ld = ($urandom_range(0, 15) == 0);
      r_lv = 8'($urandom);
      #1;
      chk($sformatf("rnd%0d_tc", c), r_tc, r_ud ? (ref_b == 8'hff) : (ref_b == 8'h00));
      ref_w = 1'b0;
      if (r_ld) begin
        ref_b = g2b8(r_lv);
      end else if (r_en) begin
        if (r_ud) begin
          ref_w = (ref_b == 8'hff);
          ref_b = ref_b + 8'd1;
        end else begin
          ref_w = (ref_b == 8'h00);
          ref_b = ref_b - 8'd1;
        end
      end
      tick();
      chk($sformatf("rnd%0d_gray", c), g2b8(r_g), ref_b);
      chk($sformatf("rnd%0d_bin", c), r_b, ref_b);
      chk($sformatf("rnd%0d_wrap", c), r_wr, ref_w);
    end
    r_en = 0; r_ld = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
